// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, datapath
// select codes, FSM states and the bundled control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_RT      = 2'd0,
        SRC_B_FOUR    = 2'd1,
        SRC_B_IMM     = 2'd2,
        SRC_B_IMM_SH2 = 2'd3
    } src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        logic    i_or_d;
        logic    ir_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_2_reg;
        logic    reg_dst;
        logic    reg_write;
        logic    alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        pc_src_e pc_source;
    } ctrl_t;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory cycles; timeout fires in the cycle whose miss
// would bring the count to MEM_WAIT_MAX, so the FSM waits at most that many cycles.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (active && !mem_ready) begin
            count <= count + 8'd1;
        end
    end

    // mem_ready in the same cycle wins: timeout is qualified by !mem_ready.
    assign timeout = active && !mem_ready && (count == 8'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: registered state, combinational control decode,
// sticky fault flags and a wrapping retired-instruction counter.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              opcode,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic                    i_or_d,
    output logic                    ir_write,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    mem_2_reg,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              pc_source,
    output logic                    illegal_instr,
    output logic                    bus_error,
    output logic [RETIRE_CNT_W-1:0] retired_cnt
);

    state_e     state, state_next;
    logic [5:0] op_q;
    ctrl_t      ctrl, ctrl_out;
    logic       timeout, wait_active, wait_clear;
    logic       retire, set_illegal, set_bus_error;

    assign wait_active = is_wait_state(state);
    assign wait_clear  = (state_next != state);

    mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (wait_clear),
        .active    (wait_active),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            op_q          <= '0;
            retired_cnt   <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) op_q <= opcode;
            if (retire)            retired_cnt <= retired_cnt + RETIRE_CNT_W'(1);
            if (set_illegal)       illegal_instr <= 1'b1;
            if (set_bus_error)     bus_error <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        ctrl          = '0;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = S_DECODE;
                end else if (timeout) begin
                    set_bus_error = 1'b1;
                    state_next    = S_HALT;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_next = S_EXEC;
                    OP_LW, OP_SW:      state_next = S_MEM_ADDR;
                    OP_BEQ:            state_next = S_BRANCH;
                    OP_J:              state_next = S_JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                if (op_q == OP_RTYPE) begin
                    ctrl.alu_src_b = SRC_B_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                end else begin
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = (op_q == OP_RTYPE);
                retire         = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_next     = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    set_bus_error = 1'b1;
                    state_next    = S_HALT;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_2_reg = 1'b1;
                retire         = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    set_bus_error = 1'b1;
                    state_next    = S_HALT;
                end
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                retire             = 1'b1;
                state_next         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
                retire         = 1'b1;
                state_next     = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes stay quiet for the whole reset pulse, even though state already reads FETCH.
    assign ctrl_out = rst ? '0 : ctrl;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign mem_2_reg     = ctrl_out.mem_2_reg;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an instruction-level model queues the expected control word
// for every cycle; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control_unit;

    localparam int MAXW = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = '0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
    logic          mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic          illegal_instr, bus_error;
    logic [CW-1:0] retired_cnt;

    multicycle_control_unit #(.MEM_WAIT_MAX(MAXW), .RETIRE_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Control word: {pcw pcwc iord irw mr mw m2r rdst rw sa, alu_src_b, alu_op, pc_source}
    localparam logic [15:0] V_ZERO       = {10'b0000000000, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] V_FETCH_WAIT = {10'b0000100000, 2'd1, 2'd0, 2'd0};
    localparam logic [15:0] V_FETCH_DONE = {10'b1001100000, 2'd1, 2'd0, 2'd0};
    localparam logic [15:0] V_DECODE     = {10'b0000000000, 2'd3, 2'd0, 2'd0};
    localparam logic [15:0] V_EXEC_R     = {10'b0000000001, 2'd0, 2'd2, 2'd0};
    localparam logic [15:0] V_EXEC_I     = {10'b0000000001, 2'd2, 2'd0, 2'd0};
    localparam logic [15:0] V_WB_R       = {10'b0000000110, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] V_WB_I       = {10'b0000000010, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] V_MADDR      = {10'b0000000001, 2'd2, 2'd0, 2'd0};
    localparam logic [15:0] V_MRD        = {10'b0010100000, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] V_MWB        = {10'b0000001010, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] V_MWR        = {10'b0010010000, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] V_BR         = {10'b0100000001, 2'd0, 2'd1, 2'd1};
    localparam logic [15:0] V_JMP        = {10'b1000000000, 2'd0, 2'd0, 2'd2};

    typedef struct packed {
        logic [15:0]   ctrl;
        logic          illegal;
        logic          bus_err;
        logic [CW-1:0] retired;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string name;
    } item_t;

    item_t         sb_q[$];
    int            checks = 0;
    int            failures = 0;

    // Architectural model state
    logic          m_illegal = 1'b0;
    logic          m_bus = 1'b0;
    logic [CW-1:0] m_retired = '0;
    bit            m_halted = 1'b0;

    function automatic obs_t observe();
        obs_t o;
        o.ctrl    = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
                     mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
        o.illegal = illegal_instr;
        o.bus_err = bus_error;
        o.retired = retired_cnt;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got ctrl=%b ill=%b bus=%b ret=%0d, want ctrl=%b ill=%b bus=%b ret=%0d",
                     name, $time, act.ctrl, act.illegal, act.bus_err, act.retired,
                     exp.ctrl, exp.illegal, exp.bus_err, exp.retired);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.name, observe(), it.exp);
        end
    end

    function automatic logic [5:0] rand_op();
        return 6'($urandom);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what that cycle must show.
    task automatic step(input string name, input logic [15:0] v, input logic rdy,
                        input logic [5:0] op, input logic rs);
        item_t it;
        @(posedge clk);
        #1;
        rst       = rs;
        mem_ready = rdy;
        opcode    = op;
        it.exp.ctrl    = v;
        it.exp.illegal = m_illegal;
        it.exp.bus_err = m_bus;
        it.exp.retired = m_retired;
        it.name        = name;
        sb_q.push_back(it);
    endtask

    task automatic step_x(input string name, input logic [15:0] v);
        step(name, v, 1'($urandom), rand_op(), 1'b0);
    endtask

    // Flags and counter hold their old value in the first reset cycle, then read zero.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            step("reset", V_ZERO, 1'($urandom), rand_op(), 1'b1);
            m_illegal = 1'b0;
            m_bus     = 1'b0;
            m_retired = '0;
            m_halted  = 1'b0;
        end
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) step_x("halt", V_ZERO);
    endtask

    // A memory access acknowledged after w idle cycles; gives up after MAXW misses.
    task automatic wait_phase(input string name, input logic [15:0] wait_v,
                              input logic [15:0] done_v, input int w, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            if (k == w) begin
                step(name, done_v, 1'b1, rand_op(), 1'b0);
                ok = 1'b1;
                return;
            end
            step(name, wait_v, 1'b0, rand_op(), 1'b0);
        end
        m_bus    = 1'b1;
        m_halted = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wd);
        bit ok;
        if (m_halted) return;
        wait_phase("fetch", V_FETCH_WAIT, V_FETCH_DONE, wf, ok);
        if (!ok) return;
        step("decode", V_DECODE, 1'($urandom), op, 1'b0);
        case (op)
            6'h00: begin step_x("exec_r", V_EXEC_R); step_x("alu_wb_r", V_WB_R); m_retired++; end
            6'h08: begin step_x("exec_i", V_EXEC_I); step_x("alu_wb_i", V_WB_I); m_retired++; end
            6'h23: begin
                step_x("mem_addr_lw", V_MADDR);
                wait_phase("mem_rd", V_MRD, V_MRD, wd, ok);
                if (!ok) return;
                step_x("mem_wb", V_MWB);
                m_retired++;
            end
            6'h2B: begin
                step_x("mem_addr_sw", V_MADDR);
                wait_phase("mem_wr", V_MWR, V_MWR, wd, ok);
                if (!ok) return;
                m_retired++;
            end
            6'h04: begin step_x("branch", V_BR); m_retired++; end
            6'h02: begin step_x("jump", V_JMP); m_retired++; end
            default: begin m_illegal = 1'b1; m_halted = 1'b1; end
        endcase
    endtask

    logic [5:0] legal_ops [6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};

    initial begin
        logic [5:0] op;
        int         wf, wd;

        repeat (2) @(posedge clk);
        do_reset(2);

        // R-type with immediate handshakes, then LW with a 3-cycle data wait
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 3);
        // SW followed by BEQ
        run_instr(6'h2B, 0, 0);
        run_instr(6'h04, 1, 0);
        run_instr(6'h08, 2, 0);

        // Illegal opcode parks in HALT until reset
        run_instr(6'h3F, 0, 0);
        halt_cycles(20);
        do_reset(1);
        run_instr(6'h00, 0, 0);

        // Fetch timeout, then a handshake landing on the last allowed cycle
        run_instr(6'h00, MAXW, 0);
        halt_cycles(5);
        do_reset(1);
        run_instr(6'h00, MAXW - 1, 0);
        run_instr(6'h23, 0, MAXW);
        halt_cycles(3);
        do_reset(1);

        // Retire counter wraps after 16 jumps
        for (int i = 0; i < 16; i++) run_instr(6'h02, 0, 0);
        run_instr(6'h00, 0, 0);

        // Reset lands in the middle of a load's data wait
        do_reset(1);
        run_instr(6'h02, 0, 0);
        step_x("fetch_lw", V_FETCH_DONE);
        step("decode_lw", V_DECODE, 1'b0, 6'h23, 1'b0);
        step_x("mem_addr_lw", V_MADDR);
        step("mem_rd_wait", V_MRD, 1'b0, rand_op(), 1'b0);
        step("mem_rd_wait", V_MRD, 1'b0, rand_op(), 1'b0);
        do_reset(1);
        run_instr(6'h2B, 0, 2);

        // Randomised instruction stream
        for (int n = 0; n < 150; n++) begin
            if (m_halted) begin
                halt_cycles(2);
                do_reset(1 + int'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 15) == 0) begin
                do op = rand_op(); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            wf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAXW)) : int'($urandom_range(0, 2));
            wd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAXW)) : int'($urandom_range(0, 2));
            run_instr(op, wf, wd);
        end

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected cycles never compared, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
